// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - PS/2 keyboard receiver line and event bundle
// Ports (signals):
//   ps2_clk, ps2_data          : asynchronous PS/2 lines into the receiver
//   rx_byte, rx_strobe, rx_err : raw byte channel
//   key_code, key_pressed, key_extended, key_strobe, key_toggle : key events
// master = receiver side, slave = line source / event consumer side.
interface ps2_kbd_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_pressed;
    logic       key_extended;
    logic       key_strobe;
    logic       key_toggle;

    modport master (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_strobe, rx_err,
        output key_code, key_pressed, key_extended, key_strobe, key_toggle
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_strobe, rx_err,
        input  key_code, key_pressed, key_extended, key_strobe, key_toggle
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - passive PS/2 keyboard frame receiver and set-2 scancode decoder
// Ports:
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : ps2_kbd_rx_if.master (PS/2 lines in, byte and key events out)
module ps2_kbd_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic           clk_sys,
    input  logic           reset,
    ps2_kbd_rx_if.master   bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input synchronisers; idle line level is high, so reset to 1 to avoid a fake edge.
    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic r_clk_f;
    logic [3:0] r_flt_cnt;
    logic w_flip, w_fall;

    // The filtered clock flips on the FILTER-th consecutive sample that disagrees with it.
    assign w_flip = (r_clk_s2 != r_clk_f) && (r_flt_cnt == 4'(FILTER - 1));
    assign w_fall = w_flip && r_clk_f;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (w_flip) begin
                r_clk_f   <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

    // Frame FSM
    state_t       r_state, w_state_nxt;
    logic [2:0]   r_bit_cnt, w_bit_nxt;
    logic [7:0]   r_shift, w_shift_nxt;
    logic         r_parity, w_par_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic         w_good, w_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_parity;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (r_state != S_IDLE && !w_flip && r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            w_state_nxt = S_IDLE;
            w_bad       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt = {r_dat_s2, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    w_par_nxt   = r_dat_s2;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if ((^r_shift ^ r_parity) && r_dat_s2)
                        w_good = 1'b1;
                    else
                        w_bad = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    logic [7:0] r_rx_byte;
    logic       r_rx_strobe, r_rx_err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tmo_cnt   <= '0;
            r_rx_byte   <= '0;
            r_rx_strobe <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_par_nxt;
            r_rx_strobe <= w_good;
            r_rx_err    <= w_bad;
            if (w_good)
                r_rx_byte <= r_shift;
            if (r_state == S_IDLE || w_flip)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Scancode decoder, driven by the registered byte strobe
    logic       r_ext, r_rel;
    logic [2:0] r_skip;
    logic [7:0] r_key_code;
    logic       r_key_pressed, r_key_extended, r_key_strobe, r_key_toggle;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ext          <= 1'b0;
            r_rel          <= 1'b0;
            r_skip         <= '0;
            r_key_code     <= '0;
            r_key_pressed  <= 1'b0;
            r_key_extended <= 1'b0;
            r_key_strobe   <= 1'b0;
            r_key_toggle   <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            if (r_rx_err) begin
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
                r_skip <= '0;
            end else if (r_rx_strobe) begin
                if (r_skip != 3'd0) begin
                    // Pause: the 7 bytes after E1 are swallowed and reported as one 0x77 make.
                    r_skip <= r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        r_key_code     <= 8'h77;
                        r_key_pressed  <= 1'b1;
                        r_key_extended <= 1'b0;
                        r_key_strobe   <= 1'b1;
                        r_key_toggle   <= ~r_key_toggle;
                    end
                end else begin
                    case (r_rx_byte)
                        8'hE0: r_ext <= 1'b1;
                        8'hF0: r_rel <= 1'b1;
                        8'hE1: begin
                            r_skip <= 3'd7;
                            r_ext  <= 1'b0;
                            r_rel  <= 1'b0;
                        end
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                        default: begin
                            r_key_code     <= r_rx_byte;
                            r_key_pressed  <= ~r_rel;
                            r_key_extended <= r_ext;
                            r_key_strobe   <= 1'b1;
                            r_key_toggle   <= ~r_key_toggle;
                            r_ext          <= 1'b0;
                            r_rel          <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.rx_byte      = r_rx_byte;
    assign bus.rx_strobe    = r_rx_strobe;
    assign bus.rx_err       = r_rx_err;
    assign bus.key_code     = r_key_code;
    assign bus.key_pressed  = r_key_pressed;
    assign bus.key_extended = r_key_extended;
    assign bus.key_strobe   = r_key_strobe;
    assign bus.key_toggle   = r_key_toggle;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed self-checking bench for ps2_kbd_rx
module tb_ps2_kbd_rx;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0;
    int   n_rx = 0, n_err = 0, n_key = 0;
    int   last_rx_cyc = 0, last_key_cyc = 0;
    int   rx0, err0, key0;

    ps2_kbd_rx_if u_if ();

    ps2_kbd_rx #(.FILTER(4), .TIMEOUT(1000)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (u_if.master)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (u_if.rx_strobe)  begin n_rx++;  last_rx_cyc  = cyc; end
            if (u_if.rx_err)     n_err++;
            if (u_if.key_strobe) begin n_key++; last_key_cyc = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One PS/2 bit cell of 200 cycles; optional 2-cycle low glitch in the high phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        u_if.ps2_data = b;
        wait_cyc(50);
        u_if.ps2_clk = 1'b0;
        wait_cyc(100);
        u_if.ps2_clk = 1'b1;
        if (glitch) begin
            wait_cyc(30);
            u_if.ps2_clk = 1'b0;
            wait_cyc(2);
            u_if.ps2_clk = 1'b1;
            wait_cyc(18);
        end else begin
            wait_cyc(50);
        end
    endtask

    // Sends the first nbits of a frame; glitch_at selects a bit cell to glitch (-1 none).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int nbits, input int glitch_at);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i], i == glitch_at);
        u_if.ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, -1);
    endtask

    task automatic snap();
        rx0 = n_rx; err0 = n_err; key0 = n_key;
    endtask

    initial begin
        u_if.ps2_clk  = 1'b1;
        u_if.ps2_data = 1'b1;
        wait_cyc(5);
        chk("reset_rx_byte", {24'd0, u_if.rx_byte}, 32'h0);
        chk("reset_key_toggle", {31'd0, u_if.key_toggle}, 32'h0);
        reset = 1'b0;
        wait_cyc(10);

        // 1: single make code
        snap();
        good(8'h1C);
        chk("t1_rx_count", n_rx - rx0, 1);
        chk("t1_rx_byte", {24'd0, u_if.rx_byte}, 32'h1C);
        chk("t1_key_count", n_key - key0, 1);
        chk("t1_key_latency", last_key_cyc - last_rx_cyc, 1);
        chk("t1_key_code", {24'd0, u_if.key_code}, 32'h1C);
        chk("t1_flags", {29'd0, u_if.key_pressed, u_if.key_extended, u_if.key_toggle}, 32'b101);

        // 2: extended break
        snap();
        good(8'hE0); good(8'hF0); good(8'h75);
        chk("t2_rx_count", n_rx - rx0, 3);
        chk("t2_key_count", n_key - key0, 1);
        chk("t2_key_code", {24'd0, u_if.key_code}, 32'h75);
        chk("t2_flags", {29'd0, u_if.key_pressed, u_if.key_extended, u_if.key_toggle}, 32'b010);

        // 3: parity error cancels prefix, stop error
        snap();
        good(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        chk("t3_par_err", n_err - err0, 1);
        chk("t3_par_rx_count", n_rx - rx0, 1);
        chk("t3_rx_byte_kept", {24'd0, u_if.rx_byte}, 32'hE0);
        good(8'h1C);
        chk("t3_key_count", n_key - key0, 1);
        chk("t3_key_code", {24'd0, u_if.key_code}, 32'h1C);
        chk("t3_flags", {29'd0, u_if.key_pressed, u_if.key_extended, u_if.key_toggle}, 32'b101);
        snap();
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        chk("t3_stop_err", n_err - err0, 1);
        chk("t3_stop_rx_count", n_rx - rx0, 0);

        // 4: timeout on partial frame
        snap();
        send_frame(8'h00, 1'b0, 1'b1, 5, -1);
        chk("t4_no_early_err", n_err - err0, 0);
        wait_cyc(1100);
        chk("t4_timeout_err", n_err - err0, 1);
        good(8'h2A);
        chk("t4_rx_byte", {24'd0, u_if.rx_byte}, 32'h2A);
        chk("t4_key_code", {24'd0, u_if.key_code}, 32'h2A);
        chk("t4_key_count", n_key - key0, 1);

        // 5: pause sequence then ack
        snap();
        good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
        good(8'hF0); good(8'h14); good(8'hF0);
        chk("t5_no_key_before_last", n_key - key0, 0);
        good(8'h77);
        chk("t5_rx_count", n_rx - rx0, 8);
        chk("t5_key_count", n_key - key0, 1);
        chk("t5_key_code", {24'd0, u_if.key_code}, 32'h77);
        chk("t5_flags", {30'd0, u_if.key_pressed, u_if.key_extended}, 32'b10);
        snap();
        good(8'hFA);
        chk("t5_fa_rx", n_rx - rx0, 1);
        chk("t5_fa_no_key", n_key - key0, 0);

        // 6: glitches and mid-frame reset
        snap();
        u_if.ps2_clk = 1'b0;
        wait_cyc(2);
        u_if.ps2_clk = 1'b1;
        wait_cyc(50);
        chk("t6_idle_glitch", (n_rx - rx0) + (n_err - err0), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 3);
        chk("t6_glitch_err", n_err - err0, 0);
        chk("t6_glitch_rx_byte", {24'd0, u_if.rx_byte}, 32'h5A);
        chk("t6_glitch_key", {24'd0, u_if.key_code}, 32'h5A);
        send_frame(8'h1C, 1'b0, 1'b1, 6, -1);
        reset = 1'b1;
        wait_cyc(3);
        chk("t6_reset_rx", {24'd0, u_if.rx_byte}, 32'h0);
        chk("t6_reset_key", {24'd0, u_if.key_code}, 32'h0);
        chk("t6_reset_bits", {27'd0, u_if.rx_strobe, u_if.rx_err, u_if.key_pressed,
                              u_if.key_extended, u_if.key_toggle}, 32'h0);
        reset = 1'b0;
        wait_cyc(10);
        snap();
        good(8'h1C);
        chk("t6_after_reset_rx", {24'd0, u_if.rx_byte}, 32'h1C);
        chk("t6_after_reset_err", n_err - err0, 0);
        chk("t6_after_reset_flags", {29'd0, u_if.key_pressed, u_if.key_extended, u_if.key_toggle}, 32'b101);
        chk("t6_after_reset_code", {24'd0, u_if.key_code}, 32'h1C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Core-side receiver for the emulated PS/2 keyboard link driven by the HPS I/O block. It deserialises PS/2 device-to-host frames from the ps2_kbd_clk/ps2_kbd_data pair and checks framing and odd parity. It then decodes set-2 scancode prefixes (E0, F0, E1) into single key events for the core's keyboard logic. It runs entirely in clk_sys and is purely passive: it never drives the PS/2 lines.

Parameters:
FILTER, 4, number of consecutive identical synchronised samples required to accept a new ps2_clk level (glitch filter), range 2..15
TIMEOUT, 50000, clk_sys cycles without a filtered ps2_clk edge after which a partial frame is abandoned, must be >1

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  PS/2 clock from the link (asynchronous)
ps2_data  in  1  PS/2 data from the link (asynchronous)
rx_byte  out  8  last correctly received byte
rx_strobe  out  1  one-cycle pulse, rx_byte updated
rx_err  out  1  one-cycle pulse on parity, stop or timeout error
key_code  out  8  scancode of last key event (without prefixes)
key_pressed  out  1  1 = make, 0 = break
key_extended  out  1  1 = E0-prefixed code
key_strobe  out  1  one-cycle pulse, key_* updated
key_toggle  out  1  inverts on every key event (for CDC consumers)

Behaviour:
- Reset: all outputs 0; frame FSM IDLE; bit counter, timeout counter, ext/rel flags and skip counter cleared. Reset overrides all other events, including reset arriving mid-frame.
- Input path: 2-FF synchroniser on both lines.
  - Filtered clock changes level only after FILTER consecutive equal samples, so pulses shorter than FILTER cycles are ignored.
  - A falling edge is the cycle the filtered clock goes 1->0. ps2_data (synchronised) is sampled in that cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP), advanced on each falling edge:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE (spurious edge, no error).
  - DATA: shift the bit in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: frame is good iff the XOR of the 8 data bits and the parity bit is 1 and the stop bit is 1.
    - Good: rx_byte <= data and rx_strobe pulses in the next cycle.
    - Otherwise: rx_err pulses and rx_byte is unchanged.
    - Either way -> IDLE.
- Timeout: the counter clears on any filtered clock edge and whenever the FSM is IDLE. If it reaches TIMEOUT-1 while not IDLE: FSM -> IDLE, rx_err pulses. A new start bit after that is accepted normally.
- Decoder, acting on each rx_strobe. key_strobe and the key_* outputs follow rx_strobe by exactly one cycle.
  - skip>0: decrement skip. If skip becomes 0, emit event code=0x77, pressed=1, extended=0. No other action.
  - E0: ext<=1, no event.
  - F0: rel<=1, no event.
  - E1: skip<=7, ext/rel cleared, no event (pause sequence, 8 bytes total).
  - FA, AA, EE, FE, 00, FF: no event, ext/rel cleared.
  - Any other byte: event code=byte, pressed=~rel, extended=ext. Then ext/rel cleared.
  - Every event pulses key_strobe and toggles key_toggle.
- rx_err clears ext, rel and skip, so a broken multi-byte sequence never yields a key event.
- Throughput: one frame per PS/2 clock train. There is no buffering; a byte is consumed in the cycle after rx_strobe.

Test Plan:
(Common conditions: PS/2 clock period 200 clk_sys cycles, FILTER=4, TIMEOUT=1000.)
1. Frame 0x1C, parity 0, stop 1 -> rx_strobe with rx_byte=0x1C. One cycle later key_strobe with key_code=0x1C, pressed=1, extended=0, and key_toggle 0->1.
2. Bytes E0, F0, 75 -> three rx_strobes but one key_strobe (after 75) with code=0x75, pressed=0, extended=1. key_toggle flips once.
3. Three error cases:
   - E0, then 0x1C with parity 1 -> rx_err pulse, no rx_strobe for 0x1C.
   - Then 0x1C good -> event with extended=0 (ext flag was cleared).
   - Separately, stop bit 0 -> rx_err.
4. Start bit plus 4 data bits, then clock held high for 1000 cycles -> rx_err at timeout and FSM IDLE. Next full frame 0x2A -> rx_byte=0x2A, event code 0x2A.
5. Pause sequence E1 14 77 E1 F0 14 F0 77 -> 8 rx_strobes and exactly one key_strobe after the last byte, with code=0x77, pressed=1, extended=0. Then byte FA -> rx_strobe only, no key_strobe.
6. Glitch and reset cases:
   - 2-cycle low glitch on ps2_clk during IDLE and mid-frame -> no state change, and the frame still decodes correctly.
   - reset asserted after the 5th data bit -> all outputs 0. The next frame 0x1C decodes correctly.
